tc_counter_bank: RTL and testbench
==================================

Name: tc_counter_bank

Overview:
Bank of CNT_NUM independent up/down counters, each with its own preset. It runs the counter instructions of the IL processor. Per-counter status bits (done, count-up enable, count-down enable) are driven as flat vectors straight into the timer/counter status-select stage, which indexes them by tc address. A registered accumulator readback port serves the processor datapath.

Parameters:
CNT_NUM, 8, number of counters; width of every status vector.
ADDR_LEN, 3, counter address width; must satisfy 2^ADDR_LEN >= CNT_NUM.
ACC_W, 16, preset/accumulator width, unsigned.

Ports:
clk  in  1  single clock, all state on rising edge.
reset  in  1  synchronous, active-low; sampled on rising clk only.
cuReq  in  CNT_NUM  per-counter count-up rung condition (level).
cdReq  in  CNT_NUM  per-counter count-down rung condition (level).
cntWrEn  in  1  write strobe for the addressed counter.
cntOp  in  2  00 nop, 01 load preset, 10 reset counter, 11 load accumulator.
cntAddr  in  ADDR_LEN  counter addressed by a write and by readback.
cntData  in  ACC_W  data for ops 01/11.
dnOut  out  CNT_NUM  done bit: acc >= preset.
cuOut  out  CNT_NUM  registered copy of cuReq.
cdOut  out  CNT_NUM  registered copy of cdReq.
accOut  out  ACC_W  accumulator of cntAddr, registered.

Behaviour:
- Reset (reset==0 at clk edge): all preset, acc, prevCu/prevCd, cuOut, cdOut, dnOut and accOut go to 0. Reset overrides every other input. Reset mid-count discards all state.
- Edge detect per counter i:
  - upEv = cuReq[i] & ~prevCu[i]; dnEv = cdReq[i] & ~prevCd[i].
  - prev registers update every cycle, including cycles where a write hits counter i.
  - A request held high in the first cycle after reset counts once.
- Count, when no write targets counter i:
  - upEv only: acc+1, saturating at 2^ACC_W-1.
  - dnEv only: acc-1, saturating at 0.
  - Both events, or neither: acc unchanged.
- Write, when cntWrEn=1 and cntAddr=i: overrides any count on counter i in that cycle; other counters still count.
  - 01: preset <= cntData; acc unchanged.
  - 10: acc <= 0; preset unchanged.
  - 11: acc <= cntData.
  - 00: no effect.
- Out-of-range address (cntAddr >= CNT_NUM): write ignored; accOut reads 0.
- dnOut[i]: registered, computed from the next-state acc and preset, so it is valid in the same cycle the new acc is visible (1 clk after the causing edge).
  - preset=0 gives dn=1 whenever out of reset.
- cuOut/cdOut: cuReq/cdReq delayed by 1 clk; equal to prevCu/prevCd.
- accOut: registered mux of next-state acc[cntAddr], 1 clk latency from a cntAddr change. A write in cycle N is reflected on accOut at N+1.
- Counters never wrap; there is no overflow or underflow flag.

Test Plan:
1. Reset held 2 clk with cuReq=all 1 -> all outputs 0. On release, each acc=1 next clk; cuOut=all 1; dnOut=all 1 (preset=0).
2. Counter 3: load preset 5, then 5 cuReq pulses (1 high, 1 low each) -> acc reads 1..5 via accOut with cntAddr=3. dnOut[3] rises on the edge where acc becomes 5. cuReq held high 4 clk counts once.
3. Counter 0: load acc 0xFFFE, 3 up pulses -> 0xFFFF, then stays at 0xFFFF. Reset counter, 2 down pulses -> acc stays 0, dnOut[0] follows preset comparison.
4. Counter 2: cuReq and cdReq rise in the same cycle -> acc unchanged, cuOut[2]=cdOut[2]=1 next clk.
5. Counter 1 up edge coincides with a write op 11 data 0x0010 to counter 1 -> acc=0x0010 (no increment). Simultaneous up edge on counter 4 -> counter 4 increments.
6. Synchronous reset asserted while acc=7, preset=9 -> next clk acc=0, preset=0, dnOut=1 only after reset releases. No asynchronous change mid-cycle.

Source files
------------

// File: rtl/tc_counter_bank_if.sv
// Counter-bank port bundle: rung requests and write strobes toward the bank,
// per-counter status vectors and the accumulator readback coming back.
interface tc_counter_bank_if #(
  parameter int CNT_NUM  = 8,
  parameter int ADDR_LEN = 3,
  parameter int ACC_W    = 16
);
  logic [CNT_NUM-1:0]  cuReq;
  logic [CNT_NUM-1:0]  cdReq;
  logic                cntWrEn;
  logic [1:0]          cntOp;
  logic [ADDR_LEN-1:0] cntAddr;
  logic [ACC_W-1:0]    cntData;
  logic [CNT_NUM-1:0]  dnOut;
  logic [CNT_NUM-1:0]  cuOut;
  logic [CNT_NUM-1:0]  cdOut;
  logic [ACC_W-1:0]    accOut;

  modport master (
    output cuReq, cdReq, cntWrEn, cntOp, cntAddr, cntData,
    input  dnOut, cuOut, cdOut, accOut
  );

  modport slave (
    input  cuReq, cdReq, cntWrEn, cntOp, cntAddr, cntData,
    output dnOut, cuOut, cdOut, accOut
  );
endinterface

// File: rtl/tc_counter_bank.sv
// Bank of edge-triggered saturating up/down counters with presets, done flags
// and a registered accumulator readback for the IL processor datapath.
module tc_counter_bank #(
  parameter int CNT_NUM  = 8,
  parameter int ADDR_LEN = 3,
  parameter int ACC_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  tc_counter_bank_if.slave   bus_if
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [CNT_NUM-1:0]             prev_cu_q;
  logic [CNT_NUM-1:0]             prev_cd_q;
  logic [CNT_NUM-1:0]             dn_q;
  logic [CNT_NUM-1:0]             dn_d;
  logic [ACC_W-1:0]               acc_out_q;
  logic [ACC_W-1:0]               acc_out_d;
  logic [CNT_NUM-1:0][ACC_W-1:0]  acc_next;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
      logic [ACC_W-1:0] acc_q;
      logic [ACC_W-1:0] acc_d;
      logic [ACC_W-1:0] preset_q;
      logic [ACC_W-1:0] preset_d;
      logic             wr_hit;
      logic             up_ev;
      logic             dn_ev;

      assign wr_hit = bus_if.cntWrEn && (bus_if.cntAddr == ADDR_LEN'(gi));
      assign up_ev  = bus_if.cuReq[gi] & ~prev_cu_q[gi];
      assign dn_ev  = bus_if.cdReq[gi] & ~prev_cd_q[gi];

      // A write to this counter takes priority over any edge seen this cycle.
      always_comb begin
        acc_d    = acc_q;
        preset_d = preset_q;
        if (wr_hit) begin
          case (bus_if.cntOp)
            2'b01:   preset_d = bus_if.cntData;
            2'b10:   acc_d    = '0;
            2'b11:   acc_d    = bus_if.cntData;
            default: ;
          endcase
        end else if (up_ev && !dn_ev) begin
          if (acc_q != ACC_MAX) acc_d = acc_q + 1'b1;
        end else if (dn_ev && !up_ev) begin
          if (acc_q != '0) acc_d = acc_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          acc_q    <= '0;
          preset_q <= '0;
        end else begin
          acc_q    <= acc_d;
          preset_q <= preset_d;
        end
      end

      assign acc_next[gi] = acc_d;
      assign dn_d[gi]     = (acc_d >= preset_d);
    end
  endgenerate

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    acc_out_d = '0;
    for (int i = 0; i < CNT_NUM; i++) begin
      if (bus_if.cntAddr == ADDR_LEN'(i)) acc_out_d = acc_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_cu_q <= '0;
      prev_cd_q <= '0;
      dn_q      <= '0;
      acc_out_q <= '0;
    end else begin
      prev_cu_q <= bus_if.cuReq;
      prev_cd_q <= bus_if.cdReq;
      dn_q      <= dn_d;
      acc_out_q <= acc_out_d;
    end
  end

  assign bus_if.cuOut  = prev_cu_q;
  assign bus_if.cdOut  = prev_cd_q;
  assign bus_if.dnOut  = dn_q;
  assign bus_if.accOut = acc_out_q;

endmodule

// File: tb/tb_tc_counter_bank.sv
// Directed bench for tc_counter_bank: expectations are queued with each step
// and checked just after the following rising edge.
module tb_tc_counter_bank;

  localparam int K_ACC = 0;
  localparam int K_DN  = 1;
  localparam int K_CU  = 2;
  localparam int K_CD  = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];

  tc_counter_bank_if #(.CNT_NUM(8), .ADDR_LEN(3), .ACC_W(16)) bus ();

  tc_counter_bank #(.CNT_NUM(8), .ADDR_LEN(3), .ACC_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(string tag, int kind, logic [15:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  function automatic logic [15:0] observe(int kind);
    case (kind)
      K_ACC:   return bus.accOut;
      K_DN:    return {8'h00, bus.dnOut};
      K_CU:    return {8'h00, bus.cuOut};
      default: return {8'h00, bus.cdOut};
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      tests++;
      $display("[TB] %s observed=%h expected=%h", e.tag, obs, e.exp);
      assert (obs === e.exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic set_wr(logic [1:0] op, logic [2:0] addr, logic [15:0] data);
    bus.cntWrEn = 1'b1;
    bus.cntOp   = op;
    bus.cntAddr = addr;
    bus.cntData = data;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    bus.cuReq     = 8'hFF;
    bus.cdReq     = 8'h00;
    bus.cntWrEn   = 1'b0;
    bus.cntOp     = 2'b00;
    bus.cntAddr   = 3'd3;
    bus.cntData   = 16'h0000;

    // Reset held two clocks with every count-up request high.
    push("rst_acc0", K_ACC, 16'h0000);
    push("rst_dn0",  K_DN,  16'h0000);
    push("rst_cu0",  K_CU,  16'h0000);
    tick();
    push("rst_acc1", K_ACC, 16'h0000);
    push("rst_dn1",  K_DN,  16'h0000);
    push("rst_cu1",  K_CU,  16'h0000);
    push("rst_cd1",  K_CD,  16'h0000);
    tick();

    // Request held high across release counts once.
    reset = 1'b1;
    push("rel_acc3", K_ACC, 16'h0001);
    push("rel_dn",   K_DN,  16'h00FF);
    push("rel_cu",   K_CU,  16'h00FF);
    push("rel_cd",   K_CD,  16'h0000);
    tick();
    push("rel_hold_acc3", K_ACC, 16'h0001);
    push("rel_hold_cu",   K_CU,  16'h00FF);
    tick();
    bus.cuReq = 8'h00;
    push("rel_drop_cu", K_CU, 16'h0000);
    tick();

    // Counter 3: clear, preset 5, five pulses.
    set_wr(2'b10, 3'd3, 16'h0000);
    push("c3_clr_acc", K_ACC, 16'h0000);
    push("c3_clr_dn",  K_DN,  16'h00FF);
    tick();
    set_wr(2'b01, 3'd3, 16'h0005);
    push("c3_pre_acc", K_ACC, 16'h0000);
    push("c3_pre_dn",  K_DN,  16'h00F7);
    tick();
    bus.cntWrEn = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.cuReq = 8'h08;
      push("c3_up_acc", K_ACC, 16'(k));
      push("c3_up_dn",  K_DN,  (k == 5) ? 16'h00FF : 16'h00F7);
      tick();
      bus.cuReq = 8'h00;
      push("c3_lo_acc", K_ACC, 16'(k));
      tick();
    end
    bus.cuReq = 8'h08;
    for (int k = 0; k < 4; k++) begin
      push("c3_hold_acc", K_ACC, 16'h0006);
      tick();
    end
    bus.cuReq = 8'h00;
    push("c3_hold_end", K_ACC, 16'h0006);
    tick();

    // Counter 0: upper saturation, then lower saturation against preset 2.
    set_wr(2'b11, 3'd0, 16'hFFFE);
    push("c0_ld_acc", K_ACC, 16'hFFFE);
    tick();
    bus.cntWrEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.cuReq = 8'h01;
      push("c0_sat_hi", K_ACC, 16'hFFFF);
      tick();
      bus.cuReq = 8'h00;
      push("c0_sat_hi_lo", K_ACC, 16'hFFFF);
      tick();
    end
    set_wr(2'b01, 3'd0, 16'h0002);
    push("c0_pre_acc", K_ACC, 16'hFFFF);
    push("c0_pre_dn",  K_DN,  16'h00FF);
    tick();
    set_wr(2'b10, 3'd0, 16'h0000);
    push("c0_clr_acc", K_ACC, 16'h0000);
    push("c0_clr_dn",  K_DN,  16'h00FE);
    tick();
    bus.cntWrEn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.cdReq = 8'h01;
      push("c0_sat_lo", K_ACC, 16'h0000);
      push("c0_sat_dn", K_DN,  16'h00FE);
      tick();
      bus.cdReq = 8'h00;
      push("c0_sat_lo_lo", K_ACC, 16'h0000);
      tick();
    end

    // Counter 2: simultaneous up and down edges cancel.
    bus.cntAddr = 3'd2;
    bus.cuReq   = 8'h04;
    bus.cdReq   = 8'h04;
    push("c2_both_acc", K_ACC, 16'h0001);
    push("c2_both_cu",  K_CU,  16'h0004);
    push("c2_both_cd",  K_CD,  16'h0004);
    tick();
    bus.cuReq = 8'h00;
    bus.cdReq = 8'h00;
    push("c2_drop_cd", K_CD, 16'h0000);
    tick();

    // Counter 1 write beats its up edge; counter 4 still counts.
    bus.cuReq = 8'h12;
    set_wr(2'b11, 3'd1, 16'h0010);
    push("c1_wr_acc", K_ACC, 16'h0010);
    push("c1_wr_cu",  K_CU,  16'h0012);
    tick();
    bus.cntWrEn = 1'b0;
    bus.cntAddr = 3'd4;
    push("c4_inc_acc", K_ACC, 16'h0002);
    tick();
    bus.cntAddr = 3'd1;
    push("c1_noinc_acc", K_ACC, 16'h0010);
    tick();
    bus.cuReq = 8'h00;

    // Counter 5: plain decrement.
    bus.cntAddr = 3'd5;
    bus.cdReq   = 8'h20;
    push("c5_dec_acc", K_ACC, 16'h0000);
    push("c5_dec_dn",  K_DN,  16'h00FE);
    tick();
    bus.cdReq = 8'h00;
    tick();

    // Counter 6: acc 7, preset 9, then synchronous reset.
    set_wr(2'b01, 3'd6, 16'h0009);
    push("c6_pre_dn", K_DN, 16'h00BE);
    tick();
    set_wr(2'b11, 3'd6, 16'h0007);
    push("c6_ld_acc", K_ACC, 16'h0007);
    push("c6_ld_dn",  K_DN,  16'h00BE);
    tick();
    bus.cntWrEn = 1'b0;
    bus.cuReq   = 8'h40;
    reset       = 1'b0;
    #1;
    push("c6_async_acc", K_ACC, 16'h0007);
    push("c6_async_dn",  K_DN,  16'h00BE);
    drain();
    push("c6_rst_acc", K_ACC, 16'h0000);
    push("c6_rst_dn",  K_DN,  16'h0000);
    push("c6_rst_cu",  K_CU,  16'h0000);
    tick();
    bus.cuReq = 8'h00;
    reset     = 1'b1;
    push("c6_rel_acc", K_ACC, 16'h0000);
    push("c6_rel_dn",  K_DN,  16'h00FF);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
